// File: rtl/nvdla_cacc_grp_regfile.sv
// CACC configuration register file with NUM_GROUPS shadow groups: CSB writes fill the
// producer group while the datapath runs from the consumer group until dp_done retires it.
module nvdla_cacc_grp_regfile #(
  parameter int NUM_GROUPS = 2,
  parameter int SIZE_W     = 13,
  parameter int STRIDE_W   = 24,
  parameter int AW         = 32,
  localparam int PTR_W     = $clog2(NUM_GROUPS)
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic [11:0]         reg_offset,
  input  logic                reg_wr_en,
  input  logic [31:0]         reg_wr_data,
  input  logic                reg_rd_en,
  output logic [31:0]         reg_rd_data,
  output logic                reg_rd_valid,
  input  logic                dp_done,
  input  logic [31:0]         sat_count,
  output logic                op_en,
  output logic                op_en_trigger,
  output logic                wr_locked_err,
  output logic [PTR_W-1:0]    consumer_ptr,
  output logic [4:0]          cfg_batches,
  output logic [4:0]          cfg_clip_truncate,
  output logic [31:0]         cfg_cya,
  output logic [AW-1:0]       cfg_dataout_addr,
  output logic                cfg_line_packed,
  output logic                cfg_surf_packed,
  output logic [SIZE_W-1:0]   cfg_dataout_width,
  output logic [SIZE_W-1:0]   cfg_dataout_height,
  output logic [SIZE_W-1:0]   cfg_dataout_channel,
  output logic [STRIDE_W-1:0] cfg_line_stride,
  output logic [STRIDE_W-1:0] cfg_surf_stride,
  output logic                cfg_conv_mode,
  output logic [1:0]          cfg_proc_precision
);

  localparam int HI_W = (AW > 32) ? AW - 32 : 1;

  localparam logic [11:0] OFF_STATUS    = 12'h000;
  localparam logic [11:0] OFF_POINTER   = 12'h004;
  localparam logic [11:0] OFF_OP_ENABLE = 12'h008;
  localparam logic [11:0] OFF_MISC_CFG  = 12'h00c;
  localparam logic [11:0] OFF_SIZE_0    = 12'h010;
  localparam logic [11:0] OFF_SIZE_1    = 12'h014;
  localparam logic [11:0] OFF_ADDR      = 12'h018;
  localparam logic [11:0] OFF_BATCH     = 12'h01c;
  localparam logic [11:0] OFF_LINE_STR  = 12'h020;
  localparam logic [11:0] OFF_SURF_STR  = 12'h024;
  localparam logic [11:0] OFF_MAP       = 12'h028;
  localparam logic [11:0] OFF_CLIP      = 12'h02c;
  localparam logic [11:0] OFF_SAT       = 12'h030;
  localparam logic [11:0] OFF_CYA       = 12'h034;
  localparam logic [11:0] OFF_ADDR_HI   = 12'h038;

  typedef struct packed {
    logic                conv_mode;
    logic [1:0]          proc_precision;
    logic [SIZE_W-1:0]   width;
    logic [SIZE_W-1:0]   height;
    logic [SIZE_W-1:0]   channel;
    logic [31:0]         addr_lo;
    logic [HI_W-1:0]     addr_hi;
    logic [4:0]          batches;
    logic [STRIDE_W-1:0] line_stride;
    logic [STRIDE_W-1:0] surf_stride;
    logic                line_packed;
    logic                surf_packed;
    logic [4:0]          clip_truncate;
    logic [31:0]         sat;
    logic [31:0]         cya;
  } grp_t;

  grp_t                  grp_q [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] op_en_q;
  logic [PTR_W-1:0]      producer_q;
  logic [PTR_W-1:0]      consumer_q;
  logic                  wr_err_q;

  logic  grp_off;
  logic  locked;
  logic  lock_err;
  logic  grp_we;
  logic  op_en_set;
  logic  done_acc;
  grp_t  cur;
  grp_t  prod;
  logic [31:0] rd_mux;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grp_off = 1'b0;
    case (reg_offset)
      OFF_OP_ENABLE, OFF_MISC_CFG, OFF_SIZE_0, OFF_SIZE_1, OFF_ADDR, OFF_BATCH,
      OFF_LINE_STR, OFF_SURF_STR, OFF_MAP, OFF_CLIP, OFF_SAT, OFF_CYA: grp_off = 1'b1;
      OFF_ADDR_HI: grp_off = (AW > 32);
      default: grp_off = 1'b0;
    endcase
  end

  // The lock check uses the pre-clear op_en, so a write racing dp_done on its group is dropped.
  assign locked    = op_en_q[producer_q];
  assign lock_err  = reg_wr_en && grp_off && locked;
  assign grp_we    = reg_wr_en && grp_off && !locked;
  assign op_en_set = grp_we && (reg_offset == OFF_OP_ENABLE) && reg_wr_data[0];
  assign done_acc  = dp_done && op_en_q[consumer_q];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      op_en_q       <= '0;
      producer_q    <= '0;
      consumer_q    <= '0;
      wr_err_q      <= 1'b0;
      op_en_trigger <= 1'b0;
      wr_locked_err <= 1'b0;
    end else begin
      op_en_trigger <= op_en_set;
      wr_locked_err <= lock_err;
      if (lock_err)
        wr_err_q <= 1'b1;
      else if (reg_wr_en && reg_offset == OFF_STATUS && reg_wr_data[31])
        wr_err_q <= 1'b0;
      if (reg_wr_en && reg_offset == OFF_POINTER)
        producer_q <= reg_wr_data[PTR_W-1:0];
      if (op_en_set)
        op_en_q[producer_q] <= 1'b1;
      if (done_acc) begin
        op_en_q[consumer_q] <= 1'b0;
        consumer_q          <= consumer_q + 1'b1;
      end
    end
  end

  // NOTE: the group array is reset in full because every field has an architected reset value.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        grp_q[g]                <= '0;
        grp_q[g].proc_precision <= 2'b01;
      end
    end else begin
      if (done_acc)
        grp_q[consumer_q].sat <= sat_count;
      if (grp_we) begin
        case (reg_offset)
          OFF_MISC_CFG: begin
            grp_q[producer_q].conv_mode      <= reg_wr_data[0];
            grp_q[producer_q].proc_precision <= reg_wr_data[13:12];
          end
          OFF_SIZE_0: begin
            grp_q[producer_q].width  <= reg_wr_data[SIZE_W-1:0];
            grp_q[producer_q].height <= reg_wr_data[16 +: SIZE_W];
          end
          OFF_SIZE_1:   grp_q[producer_q].channel     <= reg_wr_data[SIZE_W-1:0];
          OFF_ADDR:     grp_q[producer_q].addr_lo     <= reg_wr_data;
          OFF_ADDR_HI:  grp_q[producer_q].addr_hi     <= reg_wr_data[HI_W-1:0];
          OFF_BATCH:    grp_q[producer_q].batches     <= reg_wr_data[4:0];
          OFF_LINE_STR: grp_q[producer_q].line_stride <= reg_wr_data[STRIDE_W-1:0];
          OFF_SURF_STR: grp_q[producer_q].surf_stride <= reg_wr_data[STRIDE_W-1:0];
          OFF_MAP: begin
            grp_q[producer_q].line_packed <= reg_wr_data[0];
            grp_q[producer_q].surf_packed <= reg_wr_data[16];
          end
          OFF_CLIP:     grp_q[producer_q].clip_truncate <= reg_wr_data[4:0];
          OFF_CYA:      grp_q[producer_q].cya           <= reg_wr_data;
          default: ;
        endcase
      end
    end
  end

  assign prod = grp_q[producer_q];

  always_comb begin
    rd_mux = 32'h0;
    case (reg_offset)
      OFF_STATUS:    rd_mux = {wr_err_q, 31'(op_en_q)};
      OFF_POINTER:   rd_mux = (32'(consumer_q) << 16) | 32'(producer_q);
      OFF_OP_ENABLE: rd_mux = 32'(op_en_q[producer_q]);
      OFF_MISC_CFG:  rd_mux = {18'h0, prod.proc_precision, 11'h0, prod.conv_mode};
      OFF_SIZE_0:    rd_mux = (32'(prod.height) << 16) | 32'(prod.width);
      OFF_SIZE_1:    rd_mux = 32'(prod.channel);
      OFF_ADDR:      rd_mux = prod.addr_lo;
      OFF_BATCH:     rd_mux = 32'(prod.batches);
      OFF_LINE_STR:  rd_mux = 32'(prod.line_stride);
      OFF_SURF_STR:  rd_mux = 32'(prod.surf_stride);
      OFF_MAP:       rd_mux = (32'(prod.surf_packed) << 16) | 32'(prod.line_packed);
      OFF_CLIP:      rd_mux = 32'(prod.clip_truncate);
      OFF_SAT:       rd_mux = prod.sat;
      OFF_CYA:       rd_mux = prod.cya;
      OFF_ADDR_HI:   if (AW > 32) rd_mux = 32'(prod.addr_hi);
      default:       rd_mux = 32'h0;
    endcase
  end

  // Read data holds its last value between reads; only valid drops.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      reg_rd_data  <= 32'h0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en)
        reg_rd_data <= rd_mux;
    end
  end

  assign cur                 = grp_q[consumer_q];
  assign op_en               = op_en_q[consumer_q];
  assign consumer_ptr        = consumer_q;
  assign cfg_batches         = cur.batches;
  assign cfg_clip_truncate   = cur.clip_truncate;
  assign cfg_cya             = cur.cya;
  assign cfg_line_packed     = cur.line_packed;
  assign cfg_surf_packed     = cur.surf_packed;
  assign cfg_dataout_width   = cur.width;
  assign cfg_dataout_height  = cur.height;
  assign cfg_dataout_channel = cur.channel;
  assign cfg_line_stride     = cur.line_stride;
  assign cfg_surf_stride     = cur.surf_stride;
  assign cfg_conv_mode       = cur.conv_mode;
  assign cfg_proc_precision  = cur.proc_precision;

  if (AW > 32) begin : g_addr_wide
    assign cfg_dataout_addr = {cur.addr_hi, cur.addr_lo};
  end else begin : g_addr_narrow
    assign cfg_dataout_addr = cur.addr_lo;
  end

endmodule
